// File: rtl/conveyor_seq.sv
// Shuttle sequencer: conditions buttons/sensors and issues MOTOR_ON / MOTOR_DIR toggle pulses.
// Optional motion timeout is built when MOTION_TIMEOUT_EN is defined.
module conveyor_seq #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int DWELL_CYCLES    = 5000000,
  parameter int TIMEOUT_CYCLES  = 200000000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START_BTN,
  input  logic       STOP_BTN,
  input  logic       ESTOP,
  input  logic       SENS_HOME,
  input  logic       SENS_END,
  output logic       MOTOR_ON,
  output logic       MOTOR_DIR,
  output logic [2:0] STATE,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAULT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_DWELL = 3'd2,
    S_REV   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DWW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWW-1:0] DWELL_LOAD = DWW'(DWELL_CYCLES - 1);

  logic [4:0]     raw_in;
  logic [4:0]     sync1;
  logic [4:0]     sync2;
  logic [3:0]     db_in;
  logic [3:0]     db_val;
  logic [DBW-1:0] db_cnt [4];

  logic start_prev, stop_prev, start_edge, stop_edge;
  logic estop, sens_home, sens_end;

  state_t         state, next_state;
  logic [DWW-1:0] dwell_cnt;
  logic           busy;
  logic           done_r;

  logic tgt_on, tgt_dir;
  logic on_sh, dir_sh;
  logic want_on, want_dir;
  logic motor_on_r, motor_dir_r;

  assign raw_in = {SENS_END, SENS_HOME, ESTOP, STOP_BTN, START_BTN};
  // Debounced channels: 0=start, 1=stop, 2=home, 3=end. ESTOP stays level-only.
  assign db_in     = {sync2[4], sync2[3], sync2[1], sync2[0]};
  assign estop     = sync2[2];
  assign sens_home = db_val[2];
  assign sens_end  = db_val[3];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sync1  <= '0;
      sync2  <= '0;
      db_val <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (db_in[i] == db_val[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_val[i] <= db_in[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      start_edge <= 1'b0;
      stop_edge  <= 1'b0;
    end else begin
      start_prev <= db_val[0];
      stop_prev  <= db_val[1];
      start_edge <= db_val[0] & ~start_prev;
      stop_edge  <= db_val[1] & ~stop_prev;
    end
  end

  assign busy = (state == S_FWD) || (state == S_DWELL) || (state == S_REV);

`ifdef MOTION_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tmo_cnt <= '0;
    end else if ((next_state != state) && ((next_state == S_FWD) || (next_state == S_REV))) begin
      tmo_cnt <= '0;
    end else if ((state == S_FWD) || (state == S_REV)) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (estop) begin
      next_state = S_FAULT;
    end else if (stop_edge && busy) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_edge && !sens_end) next_state = S_FWD;
        S_FWD: begin
          if (sens_end) next_state = S_DWELL;
`ifdef MOTION_TIMEOUT_EN
          else if (tmo_hit) next_state = S_FAULT;
`endif
        end
        S_DWELL: if (dwell_cnt == '0) next_state = S_REV;
        S_REV: begin
          if (sens_home) next_state = S_IDLE;
`ifdef MOTION_TIMEOUT_EN
          else if (tmo_hit) next_state = S_FAULT;
`endif
        end
        S_FAULT: if (start_edge) next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      dwell_cnt <= '0;
      done_r    <= 1'b0;
    end else begin
      if ((state != S_DWELL) && (next_state == S_DWELL)) dwell_cnt <= DWELL_LOAD;
      else if ((state == S_DWELL) && (dwell_cnt != '0)) dwell_cnt <= dwell_cnt - DWW'(1);
      done_r <= (state == S_REV) && (next_state == S_IDLE) && !stop_edge && !estop;
    end
  end

  // Never flip direction while running: stop first, then turn, then restart.
  assign tgt_on  = (state == S_FWD) || (state == S_REV);
  assign tgt_dir = (state == S_REV);

  always_comb begin
    want_on  = 1'b0;
    want_dir = 1'b0;
    if (on_sh && (!tgt_on || (dir_sh != tgt_dir))) want_on = 1'b1;
    else if (!on_sh && tgt_on && (dir_sh != tgt_dir)) want_dir = 1'b1;
    else if (!on_sh && tgt_on) want_on = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      motor_on_r  <= 1'b0;
      motor_dir_r <= 1'b0;
      on_sh       <= 1'b0;
      dir_sh      <= 1'b0;
    end else if (motor_on_r || motor_dir_r) begin
      motor_on_r  <= 1'b0;
      motor_dir_r <= 1'b0;
    end else begin
      motor_on_r  <= want_on;
      motor_dir_r <= want_dir;
      if (want_on)  on_sh  <= ~on_sh;
      if (want_dir) dir_sh <= ~dir_sh;
    end
  end

  assign MOTOR_ON  = motor_on_r;
  assign MOTOR_DIR = motor_dir_r;
  assign STATE     = state;
  assign BUSY      = busy;
  assign DONE      = done_r;
  assign FAULT     = (state == S_FAULT);

endmodule

// File: tb/tb_conveyor_seq.sv
// Directed bench for conveyor_seq with short debounce/dwell/timeout settings.
// Timeout expectations follow MOTION_TIMEOUT_EN.
module tb_conveyor_seq;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       START_BTN, STOP_BTN, ESTOP, SENS_HOME, SENS_END;
  logic       MOTOR_ON, MOTOR_DIR, BUSY, DONE, FAULT;
  logic [2:0] STATE;

  int err_cnt = 0;
  int chk_cnt = 0;
  int on_cnt = 0, dir_cnt = 0, done_cnt = 0, both_cnt = 0, adj_cnt = 0;
  bit prev_pulse = 1'b0;
  int pulse_log[$];
  int on0, dir0, done0, seq_code;

  conveyor_seq #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES(10),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .START_BTN(START_BTN),
    .STOP_BTN(STOP_BTN),
    .ESTOP(ESTOP),
    .SENS_HOME(SENS_HOME),
    .SENS_END(SENS_END),
    .MOTOR_ON(MOTOR_ON),
    .MOTOR_DIR(MOTOR_DIR),
    .STATE(STATE),
    .BUSY(BUSY),
    .DONE(DONE),
    .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  // Pulse/DONE monitor on the falling edge, mid-cycle.
  always @(negedge CLK) begin
    if (MOTOR_ON) begin on_cnt++; pulse_log.push_back(1); end
    if (MOTOR_DIR) begin dir_cnt++; pulse_log.push_back(2); end
    if (MOTOR_ON && MOTOR_DIR) both_cnt++;
    if ((MOTOR_ON || MOTOR_DIR) && prev_pulse) adj_cnt++;
    prev_pulse = MOTOR_ON || MOTOR_DIR;
    if (DONE) done_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic estop,
                               input logic home, input logic end_s);
    START_BTN = start;
    STOP_BTN  = stop;
    ESTOP     = estop;
    SENS_HOME = home;
    SENS_END  = end_s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    chk_cnt++;
    assert (observed === expected)
    else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitState(input logic [2:0] expected, input int budget, input string tag);
    int n = 0;
    while ((STATE !== expected) && (n < budget)) begin
      step(1);
      n++;
    end
    checkOutput(tag, {29'd0, STATE}, {29'd0, expected});
  endtask

  initial begin
    RESET_N = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    step(3);
    checkOutput("rst_state", {29'd0, STATE}, 32'd0);
    checkOutput("rst_motor_on", {31'd0, MOTOR_ON}, 32'd0);
    checkOutput("rst_motor_dir", {31'd0, MOTOR_DIR}, 32'd0);
    checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rst_done", {31'd0, DONE}, 32'd0);
    checkOutput("rst_fault", {31'd0, FAULT}, 32'd0);
    RESET_N = 1'b1;
    step(1);

    // Start from IDLE: one run pulse, direction already forward.
    on0 = on_cnt; dir0 = dir_cnt;
    applyStimulus(1, 0, 0, 0, 0);
    step(10);
    checkOutput("t1_state_fwd", {29'd0, STATE}, 32'd1);
    checkOutput("t1_busy", {31'd0, BUSY}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    step(2);
    checkOutput("t1_on_pulses", on_cnt - on0, 32'd1);
    checkOutput("t1_dir_pulses", dir_cnt - dir0, 32'd0);

    // End sensor: stop, dwell 10 cycles, then turn and restart in reverse.
    pulse_log.delete();
    applyStimulus(0, 0, 0, 0, 1);
    waitState(3'd2, 20, "t2_dwell_entry");
    step(9);
    checkOutput("t2_dwell_hold", {29'd0, STATE}, 32'd2);
    step(1);
    checkOutput("t2_rev_at_10", {29'd0, STATE}, 32'd3);
    applyStimulus(0, 0, 0, 0, 0);
    step(6);
    checkOutput("t2_pulse_count", pulse_log.size(), 32'd3);
    seq_code = (pulse_log.size() >= 3) ? pulse_log[0] * 100 + pulse_log[1] * 10 + pulse_log[2] : 0;
    checkOutput("t2_pulse_order", seq_code, 32'd121);
    checkOutput("t2_adjacent", adj_cnt, 32'd0);

    // Home sensor in REV: stop pulse and one DONE.
    on0 = on_cnt; dir0 = dir_cnt; done0 = done_cnt;
    applyStimulus(0, 0, 0, 1, 0);
    waitState(3'd0, 20, "t3_idle");
    checkOutput("t3_done_high", {31'd0, DONE}, 32'd1);
    step(1);
    checkOutput("t3_done_low", {31'd0, DONE}, 32'd0);
    step(8);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_done_count", done_cnt - done0, 32'd1);
    checkOutput("t3_on_pulses", on_cnt - on0, 32'd1);
    checkOutput("t3_dir_pulses", dir_cnt - dir0, 32'd0);
    checkOutput("t3_busy", {31'd0, BUSY}, 32'd0);

    // ESTOP from FWD, START ignored while ESTOP held, clear after release.
    applyStimulus(1, 0, 0, 0, 0);
    waitState(3'd1, 20, "t4_fwd");
    applyStimulus(0, 0, 0, 0, 0);
    step(6);
    on0 = on_cnt;
    applyStimulus(0, 0, 1, 0, 0);
    step(3);
    checkOutput("t4_state_fault", {29'd0, STATE}, 32'd4);
    checkOutput("t4_fault_flag", {31'd0, FAULT}, 32'd1);
    checkOutput("t4_busy", {31'd0, BUSY}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    step(3);
    checkOutput("t4_stop_pulse", on_cnt - on0, 32'd1);
    applyStimulus(1, 0, 1, 0, 0);
    step(12);
    checkOutput("t4_start_ignored", {29'd0, STATE}, 32'd4);
    applyStimulus(0, 0, 0, 0, 0);
    step(8);
    applyStimulus(1, 0, 0, 0, 0);
    waitState(3'd0, 20, "t4_fault_clear");
    checkOutput("t4_fault_off", {31'd0, FAULT}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    step(8);

    // Short START glitches never pass the debouncer.
    on0 = on_cnt; dir0 = dir_cnt;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      step(2);
      applyStimulus(0, 0, 0, 0, 0);
      step(2);
    end
    step(4);
    checkOutput("t5_glitch_state", {29'd0, STATE}, 32'd0);
    checkOutput("t5_glitch_on", on_cnt - on0, 32'd0);
    checkOutput("t5_glitch_dir", dir_cnt - dir0, 32'd0);

    // STOP during DWELL: motor already stopped, so no pulse and no DONE.
    applyStimulus(1, 0, 0, 0, 0);
    waitState(3'd1, 20, "t5_fwd");
    applyStimulus(0, 0, 0, 0, 1);
    waitState(3'd2, 20, "t5_dwell");
    applyStimulus(0, 1, 0, 0, 1);
    step(2);
    on0 = on_cnt; dir0 = dir_cnt; done0 = done_cnt;
    waitState(3'd0, 12, "t5_stop_idle");
    step(5);
    checkOutput("t5_stop_on", on_cnt - on0, 32'd0);
    checkOutput("t5_stop_dir", dir_cnt - dir0, 32'd0);
    checkOutput("t5_stop_done", done_cnt - done0, 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    step(2);
    applyStimulus(0, 0, 0, 0, 0);
    step(10);

    // Motion timeout with the end sensor never arriving.
    applyStimulus(1, 0, 0, 0, 0);
    waitState(3'd1, 20, "t6_fwd");
    applyStimulus(0, 0, 0, 0, 0);
`ifdef MOTION_TIMEOUT_EN
    step(49);
    checkOutput("t6_before_timeout", {29'd0, STATE}, 32'd1);
    on0 = on_cnt;
    step(1);
    checkOutput("t6_timeout_fault", {29'd0, STATE}, 32'd4);
    checkOutput("t6_fault_flag", {31'd0, FAULT}, 32'd1);
    step(4);
    checkOutput("t6_stop_pulse", on_cnt - on0, 32'd1);
`else
    step(200);
    checkOutput("t6_no_timeout", {29'd0, STATE}, 32'd1);
    checkOutput("t6_busy", {31'd0, BUSY}, 32'd1);
`endif

    checkOutput("both_pulses_same_cycle", both_cnt, 32'd0);
    checkOutput("back_to_back_pulses", adj_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
